fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001: Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002: Parameter IQ_DEPTH, default 3; instruction queue entries, legal range 2..8.
REQ-003: clk  input  1  single clock, all state on rising edge.
REQ-004: rst_n  input  1  asynchronous active-low reset.
REQ-005: imem_addr  output  32  byte address to instruction memory.
REQ-006: imem_rdata  input  32  instruction memory data, valid one cycle after address, little-endian word.
REQ-007: redirect_valid  input  1  branch/jump redirect request.
REQ-008: redirect_pc  input  32  redirect target.
REQ-009: out_valid  output  1  instruction available to decode.
REQ-010: out_ready  input  1  decode accepts instruction.
REQ-011: out_pc  output  32  address of presented instruction.
REQ-012: out_inst  output  32  presented instruction word.

Function
REQ-013: Instruction memory has fixed 1-cycle read latency; every issued address SHALL have its data captured from imem_rdata exactly one cycle later.
REQ-014: Issue condition: redirect_valid, or (occ_q + inflight_q < IQ_DEPTH); occ_q is registered queue occupancy and inflight_q is 1 if an issue occurred last cycle.
REQ-015: Issued address: redirect_pc when redirect_valid, else fetch_pc_q; on issue fetch_pc_q <= issued address + 4 (32-bit wrap, 0xFFFF_FFFC + 4 = 0).
REQ-016: With no issue, imem_addr SHALL hold the last issued address.
REQ-017: Captured data SHALL be pushed into the queue with its pc; push and pop in the same cycle are both permitted, occupancy unchanged.
REQ-018: out_valid/out_pc/out_inst SHALL be driven from the queue head only; no combinational path from out_ready or imem_rdata to any output.
REQ-019: Handshake: pop when out_valid && out_ready; outputs SHALL stay stable while out_valid && !out_ready.
REQ-020: Redirect: queue flushed and in-flight data discarded at the clock edge; pop in the redirect cycle is ignored; first target instruction SHALL appear at out_valid two cycles after the redirect cycle.
REQ-021: With IQ_DEPTH >= 3 and out_ready held high, throughput SHALL be one instruction per cycle.
REQ-022: Queue SHALL never overflow; push into a full queue is a design error (assertion).

Reset
REQ-023: On rst_n low: occ_q=0, inflight_q=0, fetch_pc_q=RESET_PC, out_valid=0, out_pc=0, out_inst=0, imem_addr=RESET_PC.
REQ-024: First issue (RESET_PC) in the first cycle after rst_n deasserts; out_valid=1 two cycles after deassertion.
REQ-025: Reset asserted mid-operation SHALL discard queue and in-flight data immediately.

Configuration
REQ-026: Macro FETCH_MISALIGN_CHECK_EN: when defined, adds output out_misalign (1 bit, queue-carried); a redirect_pc with [1:0] != 0 SHALL yield one queue entry with out_misalign=1, out_inst=32'h0000_0013 (NOP), and fetching SHALL stall until the next redirect.
REQ-027: When undefined, no out_misalign port; redirect_pc[1:0] SHALL be forced to 0.

Structure
REQ-028: Shared package fetch_pkg SHALL hold NOP_INST constant (32'h0000_0013), IQ entry struct {pc, inst, misalign}, default RESET_PC.
REQ-029: Queue SHALL be a sub-module fetch_iq (circular buffer, head/tail pointers, occupancy counter, flush input).

Verification
REQ-030: Reset release, out_ready=1, memory word at addr N = N -> out_pc 0,4,8,C on consecutive cycles from cycle 2, out_inst equal to out_pc.
REQ-031: out_ready=0 for 6 cycles -> occ reaches 3, imem_addr frozen, out_pc held at 0; ready=1 -> 0,4,8,C without gap or duplicate.
REQ-032: Redirect to 0x100 with full queue -> out_valid=0 one cycle, then out_pc=0x100, 0x104; no pre-redirect entries appear.
REQ-033: Redirect and out_ready=1 in the same cycle -> no stale pop; next accepted pc=0x100.
REQ-034: rst_n pulsed low mid-stream -> out_valid=0 immediately, fetch restarts at RESET_PC.
REQ-035: (FETCH_MISALIGN_CHECK_EN) redirect to 0x102 -> single entry, out_misalign=1, out_inst=0x0000_0013, no further issue until redirect to 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   // Instruction substituted for a misaligned fetch target (addi x0, x0, 0).
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One instruction queue entry.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        misalign;
   } iq_entry_t;

endpackage

// File: rtl/fetch_iq.sv
// Instruction queue: circular buffer with head/tail pointers, occupancy
// counter and a flush that empties it in one cycle. Flush wins over push/pop.
module fetch_iq
   import fetch_pkg::*;
#(
   parameter int DEPTH = 3,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int OW   = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            push_i,
   input  iq_entry_t       push_entry_i,
   input  logic            pop_i,
   output logic [OW-1:0]   occ_o,
   output logic            valid_o,
   output iq_entry_t       head_o
);

   iq_entry_t       mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [OW-1:0]   occ_q, occ_d;
   logic            do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      else                     return p + PW'(1);
   endfunction

   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !flush_i && (occ_q != '0);

   // Next-state for pointers and occupancy.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (flush_i) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         if (do_push) tail_d = ptr_inc(tail_q);
         if (do_pop)  head_d = ptr_inc(head_q);
         occ_d = occ_q + OW'(do_push) - OW'(do_pop);
      end
   end

   // Pointer/occupancy registers; reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   // Entry storage; contents are only visible through a valid head.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= push_entry_i;
   end

   assign occ_o   = occ_q;
   assign valid_o = (occ_q != '0);
   assign head_o  = valid_o ? mem_q[head_q] : '0;

`ifndef SYNTHESIS
   // Pushing into a full queue without a simultaneous pop is a design error.
   always_ff @(posedge clk) begin
      if (rst_n && do_push && !do_pop)
         assert (occ_q < OW'(DEPTH)) else $error("fetch_iq overflow");
   end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues addresses to a 1-cycle-latency instruction
// memory, captures returning words into fetch_iq and presents the queue head
// to decode with a valid/ready handshake. A redirect flushes the queue and
// drops the word in flight.
// Optional macro FETCH_MISALIGN_CHECK_EN: adds out_misalign; a misaligned
// redirect yields a single NOP entry flagged misaligned and stalls fetching
// until the next redirect. Without it the low two redirect bits are cleared.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          IQ_DEPTH = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic        out_misalign,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst
);

   localparam int OW = $clog2(IQ_DEPTH + 1);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  addr_q, addr_d;
   logic         inflight_q, inflight_d;
   logic         infl_mis_q, infl_mis_d;
   logic         stall_q, stall_d;

   logic [31:0]  redir_pc;
   logic         redir_mis;
   logic         issue;
   logic [31:0]  issue_addr;
   logic [OW-1:0] iq_occ;
   logic         iq_valid;
   iq_entry_t    iq_head;
   iq_entry_t    push_entry;
   logic         push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign redir_pc  = redirect_pc;
   assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
   assign redir_mis = 1'b0;
`endif

   // Issue decision, memory address and fetch state next-values.
   always_comb begin
      issue = redirect_valid ||
              (!stall_q && ((32'(iq_occ) + 32'(inflight_q)) < 32'(IQ_DEPTH)));
      issue_addr = redirect_valid ? redir_pc : fetch_pc_q;
      imem_addr  = issue ? issue_addr : addr_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      if (issue) begin
         fetch_pc_d = issue_addr + 32'd4;
         addr_d     = issue_addr;
      end
      inflight_d = issue;
      infl_mis_d = issue && redir_mis;
      stall_d    = redirect_valid ? redir_mis : stall_q;
   end

   // Fetch state registers; reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         inflight_q <= 1'b0;
         infl_mis_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         infl_mis_q <= infl_mis_d;
         stall_q    <= stall_d;
      end
   end

   // The word returning now belongs to addr_q; a redirect discards it and
   // suppresses any pop in the same cycle.
   assign push_entry.pc       = addr_q;
   assign push_entry.inst     = infl_mis_q ? NOP_INST : imem_rdata;
   assign push_entry.misalign = infl_mis_q;
   assign push = inflight_q && !redirect_valid;
   assign pop  = iq_valid && out_ready && !redirect_valid;

   fetch_iq #(.DEPTH(IQ_DEPTH)) u_iq (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (redirect_valid),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .occ_o        (iq_occ),
      .valid_o      (iq_valid),
      .head_o       (iq_head)
   );

   assign out_valid = iq_valid;
   assign out_pc    = iq_head.pc;
   assign out_inst  = iq_head.misalign ? NOP_INST : iq_head.inst;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign out_misalign = iq_head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory model returns word N at address N.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        out_misalign;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
      .out_misalign   (out_misalign),
`endif
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst)
   );

   always #5 clk = ~clk;

   // One-cycle-latency memory: word at address N is N.
   always_ff @(posedge clk) imem_rdata <= imem_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic rdy);
      rst_n          = 1'b0;
      out_ready      = rdy;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      step(2);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_pc",    out_pc,         32'h0);
      check("rst_inst",  out_inst,       32'h0);
      check("rst_addr",  imem_addr,      32'h0);

      // Streaming with ready high.
      rst_n = 1'b1;
      check("c0_addr", imem_addr, 32'h0);
      step(1);
      check("c1_valid", 32'(out_valid), 32'd0);
      check("c1_addr",  imem_addr,      32'h4);
      step(1);
      for (int k = 0; k < 4; k++) begin
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_pc",    out_pc,   32'(k * 4));
         check("stream_inst",  out_inst, 32'(k * 4));
         step(1);
      end

      // Backpressure: queue fills, address freezes, head held.
      do_reset(1'b0);
      step(1);
      check("bp_addr1", imem_addr, 32'h4);
      step(1);
      check("bp_pc0",   out_pc,    32'h0);
      check("bp_addr2", imem_addr, 32'h8);
      step(4);
      check("bp_occ",    32'(dut.iq_occ), 32'd3);
      check("bp_frozen", imem_addr,       32'h8);
      check("bp_hold",   out_pc,          32'h0);
      check("bp_hvalid", 32'(out_valid),  32'd1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step(1);
         check("bp_drain_valid", 32'(out_valid), 32'd1);
         check("bp_drain_pc",    out_pc,         32'(k * 4));
      end

      // Redirect with a full queue.
      do_reset(1'b0);
      step(6);
      check("rd_full", 32'(dut.iq_occ), 32'd3);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      #1;
      check("rd_addr", imem_addr, 32'h100);
      step(1);
      redirect_valid = 1'b0; out_ready = 1'b1;
      check("rd_gap", 32'(out_valid), 32'd0);
      step(1);
      check("rd_v0",   32'(out_valid), 32'd1);
      check("rd_pc0",  out_pc,   32'h100);
      check("rd_ins0", out_inst, 32'h100);
      step(1);
      check("rd_pc1",  out_pc,   32'h104);

      // Redirect coinciding with an accepted handshake.
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      step(1);
      redirect_valid = 1'b0;
      check("rp_gap", 32'(out_valid), 32'd0);
      step(1);
      check("rp_v",   32'(out_valid), 32'd1);
      check("rp_pc0", out_pc, 32'h100);
      step(1);
      check("rp_pc1", out_pc, 32'h104);

      // Address wrap at the top of the space.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step(1);
      redirect_valid = 1'b0;
      step(1);
      check("wrap_top", out_pc, 32'hFFFF_FFFC);
      step(1);
      check("wrap_zero", out_pc, 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned redirect: one flagged NOP, then fetching stalls.
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      step(1);
      redirect_valid = 1'b0;
      step(1);
      check("mis_valid", 32'(out_valid),    32'd1);
      check("mis_flag",  32'(out_misalign), 32'd1);
      check("mis_inst",  out_inst,          32'h0000_0013);
      check("mis_pc",    out_pc,            32'h102);
      step(1);
      check("mis_empty", 32'(out_valid), 32'd0);
      step(3);
      check("mis_stall", 32'(out_valid), 32'd0);
      check("mis_addr",  imem_addr,      32'h102);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      step(1);
      redirect_valid = 1'b0;
      step(1);
      check("mis_res_pc",   out_pc,            32'h200);
      check("mis_res_flag", 32'(out_misalign), 32'd0);
`else
      // Low redirect bits are cleared.
      redirect_valid = 1'b1; redirect_pc = 32'h302;
      step(1);
      redirect_valid = 1'b0;
      step(1);
      check("align_pc",   out_pc,   32'h300);
      check("align_inst", out_inst, 32'h300);
`endif

      // Mid-stream reset pulse.
      step(1);
      rst_n = 1'b0;
      #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_pc",    out_pc,         32'h0);
      check("mr_addr",  imem_addr,      32'h0);
      step(1);
      rst_n = 1'b1;
      step(1);
      check("mr_c1", 32'(out_valid), 32'd0);
      step(1);
      check("mr_v",   32'(out_valid), 32'd1);
      check("mr_pc0", out_pc, 32'h0);
      step(1);
      check("mr_pc1", out_pc, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
